alu_share_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 4-bit ALU (`alu_clean` or `alu_trojan`) between `NUM_REQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block issues at most one operation per cycle to the ALU and tracks in-flight operations by requester id. It returns each result, carry and zero flag into that requester's one-entry response buffer. It sits between the test/traffic sources and the ALU under analysis, so every requester sees identical ALU stimulus timing for side-channel comparison.

---
 rtl/alu_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/alu_share_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding for the ALU sharing controller and its clients.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 2;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD = 2'b00;
  localparam alu_op_t ALU_OP_SUB = 2'b01;
  localparam alu_op_t ALU_OP_AND = 2'b10;
  localparam alu_op_t ALU_OP_OR  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or above ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_next
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic          any;

  // rot[k] is the requester k positions above ptr
  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (j == (32'(ptr) + k) % N) rot[k] = eligible[j];
      end
    end
  end

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rot[k] && !any) begin
        off = PW'(k);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned j = 0; j < N; j++) begin
      grant[j] = any && (j == (32'(ptr) + 32'(off)) % N);
    end
    ptr_next = any ? PW'((32'(ptr) + 32'(off) + 32'd1) % N) : ptr;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin issue,
// an id-tagged in-flight pipeline and one response buffer per requester.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_op,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [NUM_REQ*WIDTH-1:0]     resp_result,
  output logic [NUM_REQ-1:0]           resp_carry,
  output logic [NUM_REQ-1:0]           resp_zero,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic [ALU_OP_W-1:0]          alu_op,
  output logic                         alu_rst_n,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic                         alu_carry_out,
  input  logic                         alu_zero_flag,
  output logic                         busy
);

  localparam int unsigned IDW   = $clog2(NUM_REQ);
  localparam int unsigned DEPTH = ALU_LATENCY + 1;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  inflight;
  logic [NUM_REQ-1:0]  cap_vec;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      ptr_next;
  logic [IDW-1:0]      gnt_id;
  logic [WIDTH-1:0]    gnt_a;
  logic [WIDTH-1:0]    gnt_b;
  logic [ALU_OP_W-1:0] gnt_op;
  logic [DEPTH-1:0]    trk_valid;
  logic [IDW-1:0]      trk_id [DEPTH];
  logic                cap;
  logic [IDW-1:0]      cap_id;

  assign alu_rst_n = ~rst;
  assign req_ready = grant;
  assign cap       = trk_valid[DEPTH-1];
  assign cap_id    = trk_id[DEPTH-1];
  assign busy      = (|trk_valid) | (|resp_valid);

  always_comb begin
    inflight = '0;
    cap_vec  = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (trk_valid[s] && trk_id[s] == IDW'(i)) inflight[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cap_vec[i] = cap && (cap_id == IDW'(i));
    end
  end

  // A full buffer may refill only when it is drained on the same edge
  assign eligible = req_valid & ~inflight & (~resp_valid | resp_ready);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  always_comb begin
    gnt_id = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    gnt_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_id = IDW'(i);
        gnt_a  = req_a[i*WIDTH +: WIDTH];
        gnt_b  = req_b[i*WIDTH +: WIDTH];
        gnt_op = req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  // Issue register drives zero when idle so ALU stimulus is deterministic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      trk_valid <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) trk_id[s] <= '0;
    end else begin
      ptr       <= ptr_next;
      alu_a     <= gnt_a;
      alu_b     <= gnt_b;
      alu_op    <= gnt_op;
      trk_valid <= {trk_valid[DEPTH-2:0], |grant};
      trk_id[0] <= gnt_id;
      for (int unsigned s = 1; s < DEPTH; s++) trk_id[s] <= trk_id[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= '0;
      resp_result <= '0;
      resp_carry  <= '0;
      resp_zero   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cap_vec[i]) begin
          resp_valid[i]                  <= 1'b1;
          resp_result[i*WIDTH +: WIDTH]  <= alu_result;
          resp_carry[i]                  <= alu_carry_out;
          resp_zero[i]                   <= alu_zero_flag;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  a_no_capture_on_drain: assert property (
    @(posedge clk) disable iff (rst) (cap_vec & resp_valid & resp_ready) == '0);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl driving a behavioural single-stage ALU.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*2-1:0] req_op = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [N*W-1:0] resp_result;
  logic [N-1:0]   resp_carry;
  logic [N-1:0]   resp_zero;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [1:0]     alu_op;
  logic           alu_rst_n;
  logic [W-1:0]   alu_result;
  logic           alu_carry_out;
  logic           alu_zero_flag;
  logic           busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rst_n(alu_rst_n),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_zero_flag(alu_zero_flag), .busy(busy)
  );

  // Reference ALU: one register stage, borrow reported as carry on SUB
  logic [W:0] alu_nxt;
  always_comb begin
    case (alu_op)
      ALU_OP_ADD: alu_nxt = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_OP_SUB: alu_nxt = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_OP_AND: alu_nxt = {1'b0, alu_a & alu_b};
      default:    alu_nxt = {1'b0, alu_a | alu_b};
    endcase
  end

  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      alu_result    <= '0;
      alu_carry_out <= 1'b0;
      alu_zero_flag <= 1'b0;
    end else begin
      alu_result    <= alu_nxt[W-1:0];
      alu_carry_out <= alu_nxt[W];
      alu_zero_flag <= (alu_nxt[W-1:0] == '0);
    end
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (alu_rst_n !== 1'b0) begin fails++; $display("FAIL reset_alu_rst_n got %b exp 0", alu_rst_n); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    tests++; if (resp_valid !== 4'b0000) begin fails++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
    tests++; if (resp_result !== 16'h0000) begin fails++; $display("FAIL reset_resp_result got %h exp 0000", resp_result); end
    tests++; if ({alu_a, alu_b, alu_op} !== 10'd0) begin fails++; $display("FAIL reset_alu_issue got %h exp 000", {alu_a, alu_b, alu_op}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tests++; if (alu_rst_n !== 1'b1) begin fails++; $display("FAIL release_alu_rst_n got %b exp 1", alu_rst_n); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 4'h3, 4'h4, ALU_OP_ADD);
    req_valid = 4'b0001; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant got %b exp 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    tests++; if ({alu_a, alu_b, alu_op} !== {4'h3, 4'h4, 2'b00}) begin fails++; $display("FAIL single_issue got %h exp %h", {alu_a, alu_b, alu_op}, {4'h3, 4'h4, 2'b00}); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0000) begin fails++; $display("FAIL single_early_resp got %b exp 0000", resp_valid); end
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0001) begin fails++; $display("FAIL single_resp_valid got %b exp 0001", resp_valid); end
    tests++; if ({resp_result[3:0], resp_carry[0], resp_zero[0]} !== {4'h7, 1'b0, 1'b0}) begin fails++; $display("FAIL single_resp got %h/%b/%b exp 7/0/0", resp_result[3:0], resp_carry[0], resp_zero[0]); end
    resp_ready = 4'b0001;
    @(negedge clk); resp_ready = '0;
    tests++; if (resp_valid !== 4'b0000) begin fails++; $display("FAIL single_drain got %b exp 0000", resp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    logic [3:0] exp_v;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_req(0, 4'h1, 4'h2, ALU_OP_ADD);
    set_req(1, 4'h5, 4'h6, ALU_OP_ADD);
    set_req(2, 4'hF, 4'hF, ALU_OP_ADD);
    set_req(3, 4'h5, 4'hA, ALU_OP_AND);
    req_valid = 4'b1111; #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL contention_grant%0d got %b exp %b", k, req_ready, exp_g); end
      @(negedge clk);
      req_valid[k] = 1'b0;
      exp_v = (k == 2) ? 4'b0001 : (k == 3) ? 4'b0011 : 4'b0000;
      tests++; if (resp_valid !== exp_v) begin fails++; $display("FAIL contention_order%0d got %b exp %b", k, resp_valid, exp_v); end
      #1;
    end
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0111) begin fails++; $display("FAIL contention_order4 got %b exp 0111", resp_valid); end
    @(negedge clk);
    tests++; if (resp_valid !== 4'b1111) begin fails++; $display("FAIL contention_order5 got %b exp 1111", resp_valid); end
    tests++; if (resp_result !== 16'h0EB3) begin fails++; $display("FAIL contention_results got %h exp 0eb3", resp_result); end
    tests++; if (resp_carry !== 4'b0100) begin fails++; $display("FAIL contention_carry got %b exp 0100", resp_carry); end
    tests++; if (resp_zero !== 4'b1000) begin fails++; $display("FAIL contention_zero got %b exp 1000", resp_zero); end
    resp_ready = 4'b1111;
    @(negedge clk); resp_ready = '0;
    tests++; if (resp_valid !== 4'b0000) begin fails++; $display("FAIL contention_drain got %b exp 0000", resp_valid); end
  endtask

  task automatic test_back_pressure();
    int gseq [3] = '{2, 3, 0};
    int gidx = 0;
    logic [3:0] exp_g;
    @(negedge clk);
    set_req(1, 4'h2, 4'h3, ALU_OP_SUB);
    req_valid = 4'b0010; #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_first_grant got %b exp 0010", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0010) begin fails++; $display("FAIL bp_held_valid got %b exp 0010", resp_valid); end
    set_req(0, 4'h1, 4'h1, ALU_OP_ADD);
    set_req(2, 4'h2, 4'h2, ALU_OP_OR);
    set_req(3, 4'h3, 4'h3, ALU_OP_AND);
    req_valid = 4'b1111;
    resp_ready = 4'b1101; #1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready !== 4'b0000) begin
        exp_g = 4'b0001 << gseq[gidx % 3];
        tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL bp_rr_cycle%0d got %b exp %b", c, req_ready, exp_g); end
        gidx++;
      end
      tests++; if (req_ready[1] !== 1'b0) begin fails++; $display("FAIL bp_blocked_cycle%0d got %b exp 0", c, req_ready[1]); end
      tests++; if ({resp_valid[1], resp_result[7:4], resp_carry[1]} !== {1'b1, 4'hF, 1'b1}) begin fails++; $display("FAIL bp_stable_cycle%0d got %b/%h/%b exp 1/f/1", c, resp_valid[1], resp_result[7:4], resp_carry[1]); end
      @(negedge clk);
    end
    tests++; if (gidx !== 12) begin fails++; $display("FAIL bp_grant_count got %0d exp 12", gidx); end
    req_valid = '0;
    repeat (4) @(negedge clk);
    resp_ready = 4'b1111;
    @(negedge clk); resp_ready = '0;
    tests++; if ({busy, resp_valid} !== 5'b0) begin fails++; $display("FAIL bp_final_idle got %b exp 00000", {busy, resp_valid}); end
  endtask

  task automatic test_drain_refill();
    @(negedge clk);
    set_req(0, 4'h1, 4'h1, ALU_OP_ADD);
    req_valid = 4'b0001; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL dr_first_grant got %b exp 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    tests++; if ({resp_valid, resp_result[3:0]} !== {4'b0001, 4'h2}) begin fails++; $display("FAIL dr_first_resp got %b/%h exp 0001/2", resp_valid, resp_result[3:0]); end
    set_req(0, 4'h0, 4'hF, ALU_OP_AND);
    req_valid = 4'b0001;
    resp_ready = 4'b0001; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL dr_refill_grant got %b exp 0001", req_ready); end
    @(negedge clk); req_valid = '0; resp_ready = '0;
    tests++; if (resp_valid !== 4'b0000) begin fails++; $display("FAIL dr_drained got %b exp 0000", resp_valid); end
    tests++; if ({alu_a, alu_b, alu_op} !== {4'h0, 4'hF, 2'b10}) begin fails++; $display("FAIL dr_issue got %h exp %h", {alu_a, alu_b, alu_op}, {4'h0, 4'hF, 2'b10}); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0001) begin fails++; $display("FAIL dr_second_valid got %b exp 0001", resp_valid); end
    tests++; if ({resp_result[3:0], resp_carry[0], resp_zero[0]} !== {4'h0, 1'b0, 1'b1}) begin fails++; $display("FAIL dr_second_resp got %h/%b/%b exp 0/0/1", resp_result[3:0], resp_carry[0], resp_zero[0]); end
    resp_ready = 4'b0001;
    @(negedge clk); resp_ready = '0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    set_req(2, 4'h1, 4'h1, ALU_OP_ADD);
    req_valid = 4'b0100;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (resp_valid !== 4'b0100) begin fails++; $display("FAIL rm_buffered got %b exp 0100", resp_valid); end
    set_req(3, 4'h1, 4'h2, ALU_OP_ADD);
    req_valid = 4'b1000; #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rm_grant got %b exp 1000", req_ready); end
    @(negedge clk); req_valid = '0;
    tests++; if (alu_a !== 4'h1) begin fails++; $display("FAIL rm_issued got %h exp 1", alu_a); end
    rst = 1'b1; #1;
    tests++; if ({resp_valid, resp_carry, resp_zero} !== 12'd0) begin fails++; $display("FAIL rm_async_resp got %h exp 000", {resp_valid, resp_carry, resp_zero}); end
    tests++; if (resp_result !== 16'h0000) begin fails++; $display("FAIL rm_async_result got %h exp 0000", resp_result); end
    tests++; if ({alu_a, alu_b, alu_op} !== 10'd0) begin fails++; $display("FAIL rm_async_issue got %h exp 000", {alu_a, alu_b, alu_op}); end
    tests++; if ({busy, alu_rst_n, req_ready} !== 6'd0) begin fails++; $display("FAIL rm_async_ctrl got %b exp 000000", {busy, alu_rst_n, req_ready}); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if ({busy, resp_valid} !== 5'b0) begin fails++; $display("FAIL rm_stale_cycle%0d got %b exp 00000", c, {busy, resp_valid}); end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if ({alu_a, alu_b, alu_op, busy, req_ready} !== 15'd0) begin fails++; $display("FAIL idle_cycle%0d got %h exp 0000", c, {alu_a, alu_b, alu_op, busy, req_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_drain_refill();
    test_reset_midflight();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
